// File: rtl/ide_timing_pkg.sv
// Shared timing definitions for the IDE task-file cycle sequencer.
package ide_timing_pkg;

    // Width of the phase counter; every phase length must fit in it.
    localparam int CNT_W   = 7;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Bus-cycle phases of the task-file sequencer.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_ACK     = 3'd3,
        ST_RECOVER = 3'd4
    } ide_state_t;

    // PIO mode 0 at 28 MHz (35.7 ns per clock), rounded up:
    // t1 70 ns, t2 165 ns, remainder of the 600 ns cycle 365 ns.
    localparam int PIO0_T_SETUP   = 2;
    localparam int PIO0_T_ACTIVE  = 5;
    localparam int PIO0_T_RECOVER = 11;

    // PIO mode 4 at 28 MHz, rounded up:
    // t1 25 ns, t2 70 ns, remainder of the 120 ns cycle 25 ns.
    localparam int PIO4_T_SETUP   = 1;
    localparam int PIO4_T_ACTIVE  = 2;
    localparam int PIO4_T_RECOVER = 1;

    localparam int DEFAULT_IORDY_TIMEOUT = 64;

    // True when a phase length can be loaded into the phase counter.
    function automatic bit timing_ok(input int v);
        return (v >= 1) && (v <= CNT_MAX);
    endfunction

endpackage

// File: rtl/ide_phase_counter.sv
// Loadable down-counter that times one bus phase. A phase loaded with N
// raises done on the Nth edge after the load edge, so the owner leaves the
// phase exactly N cycles after entering it.
module ide_phase_counter
    import ide_timing_pkg::*;
(
    input  logic             CLKCPU,
    input  logic             RESET,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    // Load a new phase length, otherwise count down and park at zero.
    always_ff @(posedge CLKCPU) begin
        if (!RESET) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ide_cycle_ctrl.sv
// Sequences 68k bus cycles in the IDE task-file window into PIO chip-select,
// DIOR/DIOW strobes, data buffer control and the DTACK reply.
//
// Handshake: a cycle is requested when IDE_SEL=1, AS=0 and DS=0 are sampled
// together in IDLE; DTACK_N=0 acknowledges it; the CPU closes it by raising
// DS, and the edge that samples DS=1 in ACK releases every output. AS=1 seen
// before ACK aborts without an acknowledge. On the drive side IORDY is only
// looked at from the final ACTIVE count onwards.
module ide_cycle_ctrl
    import ide_timing_pkg::*;
#(
    parameter int T_SETUP       = 2,
    parameter int T_ACTIVE      = 6,
    parameter int T_RECOVER     = 4,
    parameter int IORDY_TIMEOUT = DEFAULT_IORDY_TIMEOUT
) (
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic       AS,
    input  logic       DS,
    input  logic       RW,
    input  logic       IDE_SEL,
    input  logic       A12,
    input  logic       IORDY,
    output logic       IDE_CS0_N,
    output logic       IDE_CS1_N,
    output logic       IDE_DIOR_N,
    output logic       IDE_DIOW_N,
    output logic       BUF_OE_N,
    output logic       BUF_DIR,
    output logic       DTACK_N,
    output logic       TIMEOUT,
    output ide_state_t state_dbg
);

    generate
        if (!timing_ok(T_SETUP) || !timing_ok(T_ACTIVE) ||
            !timing_ok(T_RECOVER) || !timing_ok(IORDY_TIMEOUT)) begin : g_param_check
            $error("ide_cycle_ctrl: timing parameters must lie in 1..127");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] LD_ACTIVE  = CNT_W'(T_ACTIVE);
    localparam logic [CNT_W-1:0] LD_RECOVER = CNT_W'(T_RECOVER);
    localparam logic [CNT_W-1:0] LD_IORDY   = CNT_W'(IORDY_TIMEOUT);

    ide_state_t       state_q, state_d;
    logic             rw_q, rw_d;
    logic             cs1_q, cs1_d;
    logic             ext_q, ext_d;
    logic             timeout_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_done;
    logic             busy_d;
    logic             cs0_n_d, cs1_n_d, dior_n_d, diow_n_d;
    logic             buf_oe_n_d, buf_dir_d, dtack_n_d;

    ide_phase_counter u_phase (
        .CLKCPU   (CLKCPU),
        .RESET    (RESET),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    // Next phase, latched cycle attributes and next value of every output.
    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        cs1_d     = cs1_q;
        ext_d     = ext_q;
        timeout_d = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;

        case (state_q)
            ST_IDLE: begin
                if (IDE_SEL && !AS && !DS) begin
                    state_d  = ST_SETUP;
                    rw_d     = RW;
                    cs1_d    = A12;
                    cnt_load = 1'b1;
                    cnt_val  = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (AS) begin
                    state_d  = ST_RECOVER;
                    cnt_load = 1'b1;
                    cnt_val  = LD_RECOVER;
                end else if (cnt_done) begin
                    state_d  = ST_ACTIVE;
                    ext_d    = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = LD_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (AS) begin
                    state_d  = ST_RECOVER;
                    cnt_load = 1'b1;
                    cnt_val  = LD_RECOVER;
                end else if (cnt_done) begin
                    if (IORDY) begin
                        state_d = ST_ACK;
                    end else if (!ext_q) begin
                        // Drive not ready on the final count: start the IORDY wait.
                        ext_d    = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = LD_IORDY;
                    end else begin
                        // Wait budget spent: give up on IORDY and finish the cycle.
                        state_d   = ST_ACK;
                        timeout_d = 1'b1;
                    end
                end else if (ext_q && IORDY) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (DS) begin
                    state_d  = ST_RECOVER;
                    cnt_load = 1'b1;
                    cnt_val  = LD_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (cnt_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d == ST_SETUP) || (state_d == ST_ACTIVE) || (state_d == ST_ACK);
        cs0_n_d    = !(busy_d && !cs1_d);
        cs1_n_d    = !(busy_d && cs1_d);
        buf_oe_n_d = !busy_d;
        buf_dir_d  = busy_d && rw_d;
        // Reads hold DIOR through ACK; writes drop DIOW on entry to ACK.
        dior_n_d   = !(rw_d && ((state_d == ST_ACTIVE) || (state_d == ST_ACK)));
        diow_n_d   = !(!rw_d && (state_d == ST_ACTIVE));
        dtack_n_d  = !(state_d == ST_ACK);
    end

    // Phase register and latched cycle attributes.
    always_ff @(posedge CLKCPU) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            rw_q    <= 1'b0;
            cs1_q   <= 1'b0;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            cs1_q   <= cs1_d;
            ext_q   <= ext_d;
        end
    end

    // Registered outputs so no input reaches a pin combinationally.
    always_ff @(posedge CLKCPU) begin
        if (!RESET) begin
            IDE_CS0_N  <= 1'b1;
            IDE_CS1_N  <= 1'b1;
            IDE_DIOR_N <= 1'b1;
            IDE_DIOW_N <= 1'b1;
            BUF_OE_N   <= 1'b1;
            BUF_DIR    <= 1'b0;
            DTACK_N    <= 1'b1;
            TIMEOUT    <= 1'b0;
        end else begin
            IDE_CS0_N  <= cs0_n_d;
            IDE_CS1_N  <= cs1_n_d;
            IDE_DIOR_N <= dior_n_d;
            IDE_DIOW_N <= diow_n_d;
            BUF_OE_N   <= buf_oe_n_d;
            BUF_DIR    <= buf_dir_d;
            DTACK_N    <= dtack_n_d;
            TIMEOUT    <= timeout_d;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_ide_cycle_ctrl.sv
// Self-checking bench for ide_cycle_ctrl: reset checks, a table of directed
// cycles, hand-written reset/back-to-back sequences and randomized cycles
// checked every clock against an interval model of the bus timing.
module tb_ide_cycle_ctrl;
    import ide_timing_pkg::*;

    localparam int TS = 2;
    localparam int TA = 6;
    localparam int TR = 4;
    localparam int TO = 64;
    // {CS0_N, CS1_N, DIOR_N, DIOW_N, BUF_OE_N, BUF_DIR, DTACK_N, TIMEOUT}
    localparam logic [7:0] OUT_IDLE = 8'b1111_1010;

    logic       CLKCPU = 1'b0;
    logic       RESET, AS, DS, RW, IDE_SEL, A12, IORDY;
    logic       IDE_CS0_N, IDE_CS1_N, IDE_DIOR_N, IDE_DIOW_N;
    logic       BUF_OE_N, BUF_DIR, DTACK_N, TIMEOUT;
    ide_state_t state_dbg;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int last_cs_abs = -1;

    typedef struct {
        logic rw;
        logic a12;
        int   ext;
        int   dsd;
        int   abort_at;
        int   exp_cs;
        int   exp_strb;
        int   exp_dtack;
        int   exp_idle;
        int   exp_to;
    } vec_t;

    vec_t vecs[9];

    // Clock and DUT
    always #5 CLKCPU = ~CLKCPU;

    ide_cycle_ctrl #(
        .T_SETUP       (TS),
        .T_ACTIVE      (TA),
        .T_RECOVER     (TR),
        .IORDY_TIMEOUT (TO)
    ) dut (
        .CLKCPU     (CLKCPU),
        .RESET      (RESET),
        .AS         (AS),
        .DS         (DS),
        .RW         (RW),
        .IDE_SEL    (IDE_SEL),
        .A12        (A12),
        .IORDY      (IORDY),
        .IDE_CS0_N  (IDE_CS0_N),
        .IDE_CS1_N  (IDE_CS1_N),
        .IDE_DIOR_N (IDE_DIOR_N),
        .IDE_DIOW_N (IDE_DIOW_N),
        .BUF_OE_N   (BUF_OE_N),
        .BUF_DIR    (BUF_DIR),
        .DTACK_N    (DTACK_N),
        .TIMEOUT    (TIMEOUT),
        .state_dbg  (state_dbg)
    );

    // Driver helpers
    task automatic step();
        @(posedge CLKCPU);
        #1;
        edge_n++;
    endtask

    function automatic logic [7:0] dut_out();
        return {IDE_CS0_N, IDE_CS1_N, IDE_DIOR_N, IDE_DIOW_N, BUF_OE_N, BUF_DIR, DTACK_N, TIMEOUT};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic check_bits(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_n, act, exp);
        end
    endtask

    // Reference model: output levels at relative edge r of a cycle whose
    // acknowledge starts at d_edge and which is released at edge k.
    function automatic logic [7:0] model_out(input int r, input logic rw, input logic a12,
                                             input int d_edge, input int k, input bit to_flag);
        bit busy, rd_strb, wr_strb, ack, to;
        busy    = (r >= 0) && (r < k);
        rd_strb = rw && (r >= TS) && (r < k);
        wr_strb = !rw && (r >= TS) && (r < d_edge) && (r < k);
        ack     = (r >= d_edge) && (r < k);
        to      = to_flag && (r == d_edge) && (d_edge < k);
        return {!(busy && !a12), !(busy && a12), !rd_strb, !wr_strb,
                !busy, busy && rw, !ack, to};
    endfunction

    // One complete access starting at the next edge (relative edge 0).
    // ext: edges IORDY stays low from the final ACTIVE count; dsd: edges
    // from DTACK to the edge that samples DS=1; abort_at: edge that samples
    // AS=1 early (0 = none); keep_req: request again during RECOVER.
    task automatic run_txn(input logic rw, input logic a12, input int ext, input int dsd,
                           input int abort_at, input bit keep_req,
                           output int m_cs, output int m_strb, output int m_dtack,
                           output int m_idle, output int m_to, output int m_rel_abs);
        int e, d_edge, k, last;
        bit to_flag;
        e       = (ext > TO) ? TO : ext;
        to_flag = (ext > TO);
        d_edge  = TS + TA + e;
        k       = (abort_at > 0) ? abort_at : d_edge + dsd;
        last    = k + TR;
        m_cs = -1; m_strb = -1; m_dtack = -1; m_idle = -1; m_to = 0; m_rel_abs = -1;
        for (int r = 0; r <= last; r++) begin
            if (r == 0) begin
                IDE_SEL = 1'b1; AS = 1'b0; DS = 1'b0; RW = rw; A12 = a12;
            end else if (r < k) begin
                RW  = 1'($urandom_range(0, 1));
                A12 = 1'($urandom_range(0, 1));
            end else if (r == k) begin
                AS = 1'b1; DS = 1'b1; IDE_SEL = keep_req;
            end else if (keep_req) begin
                AS = 1'b0; DS = 1'b0; RW = 1'($urandom_range(0, 1));
            end else begin
                IDE_SEL = 1'b0;
            end
            if (r < TS + TA) IORDY = 1'($urandom_range(0, 1));
            else             IORDY = !(r < TS + TA + ext);
            step();
            check_bits("cycle_outputs", dut_out(), model_out(r, rw, a12, d_edge, k, to_flag));
            if (m_cs < 0 && (!IDE_CS0_N || !IDE_CS1_N)) begin
                m_cs = r;
                last_cs_abs = edge_n;
            end
            if (m_strb < 0 && (!IDE_DIOR_N || !IDE_DIOW_N)) m_strb = r;
            if (m_dtack < 0 && !DTACK_N) m_dtack = r;
            if (TIMEOUT) m_to++;
            if (m_idle < 0 && r >= k && state_dbg == ST_IDLE) m_idle = r;
            if (r == k) m_rel_abs = edge_n;
        end
    endtask

    initial begin
        int m_cs, m_strb, m_dtack, m_idle, m_to, rel1, rel2, dtack_seen;
        logic rw, a12;
        int ext, dsd, abort_at, sel;
        bit keep;

        //            rw    a12   ext  dsd abort cs strb dtack idle to
        vecs[0] = '{1'b1, 1'b0,   0,  4,  0,   0,  2,   8,  16,  0};
        vecs[1] = '{1'b0, 1'b1,   0,  2,  0,   0,  2,   8,  14,  0};
        vecs[2] = '{1'b1, 1'b0,  10,  1,  0,   0,  2,  18,  23,  0};
        vecs[3] = '{1'b0, 1'b0, 200,  1,  0,   0,  2,  72,  77,  1};
        vecs[4] = '{1'b1, 1'b1,  64,  1,  0,   0,  2,  72,  77,  0};
        vecs[5] = '{1'b0, 1'b1,  65,  3,  0,   0,  2,  72,  79,  1};
        vecs[6] = '{1'b1, 1'b0,   0,  1,  1,   0, -1,  -1,   5,  0};
        vecs[7] = '{1'b0, 1'b1,   0,  1,  5,   0,  2,  -1,   9,  0};
        vecs[8] = '{1'b1, 1'b1,  20,  1, 15,   0,  2,  -1,  19,  0};

        // Reset: outputs inactive, request ignored while RESET is low
        RESET = 1'b0; AS = 1'b1; DS = 1'b1; RW = 1'b0; IDE_SEL = 1'b0; A12 = 1'b0; IORDY = 1'b1;
        repeat (2) step();
        check_bits("reset_outputs", dut_out(), OUT_IDLE);
        check("reset_state", int'(state_dbg), int'(ST_IDLE));
        IDE_SEL = 1'b1; AS = 1'b0; DS = 1'b0; RW = 1'b1;
        step();
        check_bits("reset_blocks_request", dut_out(), OUT_IDLE);
        AS = 1'b1; DS = 1'b1; IDE_SEL = 1'b0; RESET = 1'b1;
        step();
        check_bits("after_reset_idle", dut_out(), OUT_IDLE);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].rw, vecs[i].a12, vecs[i].ext, vecs[i].dsd, vecs[i].abort_at, 1'b0,
                    m_cs, m_strb, m_dtack, m_idle, m_to, rel1);
            check($sformatf("vec%0d_cs_edge", i), m_cs, vecs[i].exp_cs);
            check($sformatf("vec%0d_strobe_edge", i), m_strb, vecs[i].exp_strb);
            check($sformatf("vec%0d_dtack_edge", i), m_dtack, vecs[i].exp_dtack);
            check($sformatf("vec%0d_idle_edge", i), m_idle, vecs[i].exp_idle);
            check($sformatf("vec%0d_timeout_pulses", i), m_to, vecs[i].exp_to);
        end

        // RESET low during ACTIVE releases everything, no DTACK follows
        IDE_SEL = 1'b1; AS = 1'b0; DS = 1'b0; RW = 1'b1; A12 = 1'b0; IORDY = 1'b1;
        repeat (5) step();
        check_bits("rst_mid_active_outputs", dut_out(), 8'b0101_0110);
        RESET = 1'b0; AS = 1'b1; DS = 1'b1; IDE_SEL = 1'b0;
        step();
        check_bits("rst_mid_released", dut_out(), OUT_IDLE);
        check("rst_mid_state", int'(state_dbg), int'(ST_IDLE));
        RESET = 1'b1;
        dtack_seen = 0;
        repeat (12) begin
            step();
            if (!DTACK_N) dtack_seen++;
        end
        check("rst_mid_no_dtack", dtack_seen, 0);
        run_txn(1'b0, 1'b0, 0, 2, 0, 1'b0, m_cs, m_strb, m_dtack, m_idle, m_to, rel1);
        check("rst_clean_dtack_edge", m_dtack, TS + TA);

        // Back-to-back reads with the request re-asserted during RECOVER
        run_txn(1'b1, 1'b0, 0, 2, 0, 1'b1, m_cs, m_strb, m_dtack, m_idle, m_to, rel1);
        check("b2b_first_dtack", m_dtack, TS + TA);
        run_txn(1'b1, 1'b1, 3, 1, 0, 1'b0, m_cs, m_strb, m_dtack, m_idle, m_to, rel2);
        check("b2b_spacing", last_cs_abs - rel1, TR + 1);
        check("b2b_second_dtack", m_dtack, TS + TA + 3);

        // Randomized cycles against the interval model
        for (int n = 0; n < 40; n++) begin
            rw  = 1'($urandom_range(0, 1));
            a12 = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 5)      ext = 0;
            else if (sel < 8) ext = int'($urandom_range(1, 20));
            else              ext = int'($urandom_range(60, 80));
            dsd = int'($urandom_range(1, 5));
            if ($urandom_range(0, 4) == 0)
                abort_at = int'($urandom_range(1, TS + TA + ((ext > TO) ? TO : ext)));
            else
                abort_at = 0;
            keep = ($urandom_range(0, 3) == 0);
            run_txn(rw, a12, ext, dsd, abort_at, keep, m_cs, m_strb, m_dtack, m_idle, m_to, rel1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
